// File: rtl/instr_encode_loader.sv
// Loads RV32I programs into imem: buffers field-level descriptors in a small FIFO,
// encodes each one and writes it to consecutive word addresses from a base address.
module instr_encode_loader #(
  parameter int ADDR_W = 12,
  parameter int DEPTH  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [3:0]        in_kind,
  input  logic [2:0]        in_funct3,
  input  logic              in_funct7b5,
  input  logic [4:0]        in_rd,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [31:0]       in_imm,
  input  logic              in_last,
  output logic              mem_we,
  input  logic              mem_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] word_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0]    PTR_ONE   = (PTR_W + 1)'(1);
  localparam logic [ADDR_W-1:0] WORD_MASK = ~ADDR_W'(3);

  localparam logic [3:0] KIND_LW    = 4'd0;
  localparam logic [3:0] KIND_SW    = 4'd1;
  localparam logic [3:0] KIND_R     = 4'd2;
  localparam logic [3:0] KIND_BR    = 4'd3;
  localparam logic [3:0] KIND_IALU  = 4'd4;
  localparam logic [3:0] KIND_JAL   = 4'd5;
  localparam logic [3:0] KIND_JALR  = 4'd6;
  localparam logic [3:0] KIND_LUI   = 4'd7;
  localparam logic [3:0] KIND_AUIPC = 4'd8;

  typedef enum logic [1:0] {IDLE, LOAD, DONE} stateT;

  typedef struct packed {
    logic [3:0]  kind;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic        last;
  } descT;

  function automatic logic [31:0] encode(
    input logic [3:0]  kind,
    input logic [2:0]  f3,
    input logic        f7b5,
    input logic [4:0]  rd,
    input logic [4:0]  rs1,
    input logic [4:0]  rs2,
    input logic [31:0] imm
  );
    logic [31:0] w;
    w = '0;
    case (kind)
      KIND_LW:    w = {imm[11:0], rs1, 3'b010, rd, 7'b0000011};
      KIND_SW:    w = {imm[11:5], rs2, rs1, 3'b010, imm[4:0], 7'b0100011};
      KIND_R:     w = {1'b0, f7b5, 5'b00000, rs2, rs1, f3, rd, 7'b0110011};
      KIND_BR:    w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 7'b1100011};
      KIND_IALU: begin
        // Shifts carry funct7 in the upper immediate bits.
        if (f3 == 3'b001 || f3 == 3'b101)
          w = {1'b0, f7b5, 5'b00000, imm[4:0], rs1, f3, rd, 7'b0010011};
        else
          w = {imm[11:0], rs1, f3, rd, 7'b0010011};
      end
      KIND_JAL:   w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, 7'b1101111};
      KIND_JALR:  w = {imm[11:0], rs1, 3'b000, rd, 7'b1100111};
      KIND_LUI:   w = {imm[31:12], rd, 7'b0110111};
      KIND_AUIPC: w = {imm[31:12], rd, 7'b0010111};
      default:    w = '0;
    endcase
    return w;
  endfunction

  stateT             state, nextState;
  descT              fifoMem [DEPTH];
  descT              head;
  logic [PTR_W:0]    wrPtr, rdPtr;
  logic [ADDR_W-1:0] addrPtr, wordCnt;
  logic              errFlag;
  logic              fifoEmpty, fifoFull, headLegal;
  logic              push, pop, startLoad, memWe;

  assign fifoEmpty = (wrPtr == rdPtr);
  assign fifoFull  = (wrPtr[PTR_W] != rdPtr[PTR_W]) &&
                     (wrPtr[PTR_W-1:0] == rdPtr[PTR_W-1:0]);
  assign head      = fifoMem[rdPtr[PTR_W-1:0]];
  assign headLegal = (head.kind <= KIND_AUIPC);

  assign in_ready = (state == LOAD) && !fifoFull;
  assign push     = in_valid && in_ready;

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    nextState = state;
    startLoad = 1'b0;
    pop       = 1'b0;
    memWe     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          nextState = LOAD;
          startLoad = 1'b1;
        end
      end
      LOAD: begin
        if (!fifoEmpty) begin
          if (!headLegal) begin
            pop = 1'b1;
          end else begin
            memWe = 1'b1;
            pop   = mem_ready;
          end
          if (pop && head.last) nextState = DONE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= nextState;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      addrPtr <= '0;
      wordCnt <= '0;
      errFlag <= 1'b0;
    end else if (startLoad) begin
      wrPtr   <= '0;
      rdPtr   <= '0;
      addrPtr <= base_addr & WORD_MASK;
      wordCnt <= '0;
      errFlag <= 1'b0;
    end else begin
      if (push) wrPtr <= wrPtr + PTR_ONE;
      if (pop) begin
        rdPtr <= rdPtr + PTR_ONE;
        if (headLegal) begin
          addrPtr <= addrPtr + ADDR_W'(4);
          wordCnt <= wordCnt + ADDR_W'(1);
        end else begin
          errFlag <= 1'b1;
        end
      end
    end
  end

  // NOTE: FIFO storage is not reset; the pointers alone decide which entries are valid.
  always_ff @(posedge clk) begin
    if (push) begin
      fifoMem[wrPtr[PTR_W-1:0]] <= '{kind: in_kind, funct3: in_funct3, funct7b5: in_funct7b5,
                                     rd: in_rd, rs1: in_rs1, rs2: in_rs2,
                                     imm: in_imm, last: in_last};
    end
  end

  assign mem_we     = memWe;
  assign mem_addr   = addrPtr;
  assign mem_wdata  = memWe ? encode(head.kind, head.funct3, head.funct7b5, head.rd,
                                     head.rs1, head.rs2, head.imm) : '0;
  assign done       = (state == DONE);
  assign err        = errFlag;
  assign word_count = wordCnt;

endmodule
